datapath_control_sequencer: RTL and testbench



---
 rtl/datapath_control_sequencer_pkg.sv | 52 +++++
 rtl/datapath_control_sequencer_branch_cond.sv | 26 ++
 rtl/datapath_control_sequencer.sv | 135 +++++++++++++
 tb/tb_datapath_control_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_control_sequencer_pkg.sv
// Shared encodings for the datapath control sequencer: FSM states, instruction
// classes, branch condition codes, status flag positions and instruction field positions.
package datapath_control_sequencer_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_FETCH  = S_FETCH,
        ST_DECODE = S_DECODE,
        ST_EXEC   = S_EXEC,
        ST_HALT   = S_HALT
    } seq_state_t;

    localparam logic [1:0] CLS_ALU_REG = 2'b00;
    localparam logic [1:0] CLS_ALU_IMM = 2'b01;
    localparam logic [1:0] CLS_BRANCH  = 2'b10;
    localparam logic [1:0] CLS_HALT    = 2'b11;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_Z      = 3'b001;
    localparam logic [2:0] COND_NZ     = 3'b010;
    localparam logic [2:0] COND_N      = 3'b011;
    localparam logic [2:0] COND_NN     = 3'b100;
    localparam logic [2:0] COND_C      = 3'b101;
    localparam logic [2:0] COND_V      = 3'b110;
    localparam logic [2:0] COND_NEVER  = 3'b111;

    // Status vector is {V,C,N,Z}.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam int CLS_HI  = 31;
    localparam int CLS_LO  = 30;
    localparam int FS_HI   = 29;
    localparam int FS_LO   = 25;
    localparam int DA_HI   = 24;
    localparam int DA_LO   = 20;
    localparam int SA_HI   = 19;
    localparam int SA_LO   = 15;
    localparam int SB_HI   = 14;
    localparam int SB_LO   = 10;
    localparam int COND_HI = 29;
    localparam int COND_LO = 27;

endpackage

// File: rtl/datapath_control_sequencer_branch_cond.sv
// Combinational branch condition evaluator: condition code plus latched
// status flags produce the branch-taken decision.
module seq_branch_cond
    import datapath_control_sequencer_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = flags[FLAG_Z];
            COND_NZ:     taken = ~flags[FLAG_Z];
            COND_N:      taken = flags[FLAG_N];
            COND_NN:     taken = ~flags[FLAG_N];
            COND_C:      taken = flags[FLAG_C];
            COND_V:      taken = flags[FLAG_V];
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/datapath_control_sequencer.sv
// Instruction fetch/decode sequencer driving the register-file/ALU datapath controls.
// Optional build macro SEQ_RETIRE_COUNT_EN adds the 32-bit retired-instruction counter.
module datapath_control_sequencer
    import datapath_control_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int IMM_W  = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic [3:0]        status,
    output logic [4:0]        DA,
    output logic [4:0]        SA,
    output logic [4:0]        SB,
    output logic              W,
    output logic              BS,
    output logic [4:0]        FS,
    output logic [63:0]       K,
    output logic [ADDR_W-1:0] pc,
    output seq_state_t        fsm_state
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [31:0]       retired
`endif
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [3:0]        flags_q, flags_d;
    logic [1:0]        ir_cls;
    logic              taken;

    assign ir_cls = ir_q[CLS_HI:CLS_LO];

    seq_branch_cond u_branch_cond (
        .cond  (ir_q[COND_HI:COND_LO]),
        .flags (flags_q),
        .taken (taken)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    // Datapath controls are only non-zero while an ALU instruction executes.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        DA      = '0;
        SA      = '0;
        SB      = '0;
        W       = 1'b0;
        BS      = 1'b0;
        FS      = '0;
        K       = '0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d    = imem_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (ir_cls)
                    CLS_ALU_REG, CLS_ALU_IMM: begin
                        FS = ir_q[FS_HI:FS_LO];
                        DA = ir_q[DA_HI:DA_LO];
                        SA = ir_q[SA_HI:SA_LO];
                        W  = 1'b1;
                        if (ir_cls == CLS_ALU_IMM) begin
                            BS = 1'b1;
                            K  = 64'(ir_q[IMM_W-1:0]);
                        end else begin
                            SB = ir_q[SB_HI:SB_LO];
                        end
                        flags_d = status;
                        pc_d    = pc_q + ADDR_W'(1);
                    end
                    CLS_BRANCH: begin
                        pc_d = taken ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SEQ_RETIRE_COUNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            retired_q <= '0;
        end else if ((state_q == ST_IDLE || state_q == ST_HALT) && start) begin
            retired_q <= '0;
        end else if (state_q == ST_EXEC && ir_cls != CLS_HALT) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired = retired_q;
`endif

    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
    assign done      = (state_q == ST_HALT);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_datapath_control_sequencer.sv
// Testbench for datapath_control_sequencer: directed programs plus a random ROM,
// checked instruction-by-instruction against an architectural model.
module tb_datapath_control_sequencer;
    import datapath_control_sequencer_pkg::*;

    localparam int ADDR_W = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [3:0]        status;
    logic [4:0]        DA, SA, SB, FS;
    logic              W, BS;
    logic [63:0]       K;
    logic [ADDR_W-1:0] pc;
    seq_state_t        fsm_state;
`ifdef SEQ_RETIRE_COUNT_EN
    logic [31:0]       retired;
`endif

    datapath_control_sequencer #(.ADDR_W(ADDR_W), .IMM_W(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .status    (status),
        .DA        (DA),
        .SA        (SA),
        .SB        (SB),
        .W         (W),
        .BS        (BS),
        .FS        (FS),
        .K         (K),
        .pc        (pc),
        .fsm_state (fsm_state)
`ifdef SEQ_RETIRE_COUNT_EN
        ,
        .retired   (retired)
`endif
    );

    // clock / reset / ROM
    always #5 clock = ~clock;

    logic [31:0] rom [256];
    always @(posedge clock) imem_data <= rom[imem_addr];

    // architectural model and scoreboard
    int                tests = 0;
    int                fails = 0;
    logic [ADDR_W-1:0] m_pc;
    logic [3:0]        m_flags;
    logic [31:0]       m_retired;
    bit                m_halted;
    logic [ADDR_W-1:0] exp_q[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] f_alu_imm(input logic [4:0] fs, input logic [4:0] da,
                                              input logic [4:0] sa, input logic [14:0] imm);
        return {2'b01, fs, da, sa, imm};
    endfunction

    function automatic logic [31:0] f_alu_reg(input logic [4:0] fs, input logic [4:0] da,
                                              input logic [4:0] sa, input logic [4:0] sb);
        return {2'b00, fs, da, sa, sb, 10'd0};
    endfunction

    function automatic logic [31:0] f_branch(input logic [2:0] cond, input logic [7:0] target);
        return {2'b10, cond, 19'd0, target};
    endfunction

    function automatic logic [31:0] f_halt();
        return {2'b11, 30'd0};
    endfunction

    // flags f = {V,C,N,Z}
    function automatic bit cond_met(input logic [2:0] c, input logic [3:0] f);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return f[0];
            3'd2:    return !f[0];
            3'd3:    return f[1];
            3'd4:    return !f[1];
            3'd5:    return f[2];
            3'd6:    return f[3];
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc      = '0;
        m_flags   = '0;
        m_retired = '0;
        m_halted  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pc      = '0;
        m_retired = '0;
        m_halted  = 1'b0;
        check("start_pc", pc, 0);
        check("start_busy", busy, 1);
        check("start_done", done, 0);
    endtask

    // Runs one instruction from FETCH through its EXEC edge; force_st < 0 means random status.
    task automatic exec_one(input int force_st);
        logic [31:0]       ins;
        logic [1:0]        cls;
        logic [ADDR_W-1:0] nxt;
        ins = rom[m_pc];
        cls = ins[31:30];
        check("fetch_addr", imem_addr, m_pc);
        check("fetch_busy", busy, 1);
        check("fetch_w", W, 0);
        start = 1'($urandom_range(0, 1));
        tick();
        check("decode_w", W, 0);
        check("decode_k", K, 0);
        tick();
        status = (force_st >= 0) ? 4'(force_st) : 4'($urandom_range(0, 15));
        check("exec_busy", busy, 1);
        if (cls == 2'b00 || cls == 2'b01) begin
            check("alu_w", W, 1);
            check("alu_fs", FS, ins[29:25]);
            check("alu_da", DA, ins[24:20]);
            check("alu_sa", SA, ins[19:15]);
            check("alu_bs", BS, (cls == 2'b01) ? 1 : 0);
            check("alu_k", K, (cls == 2'b01) ? {49'd0, ins[14:0]} : 64'd0);
            if (cls == 2'b00) check("alu_sb", SB, ins[14:10]);
            m_flags = status;
            nxt = m_pc + 8'd1;
            m_retired++;
        end else if (cls == 2'b10) begin
            check("branch_w", W, 0);
            nxt = cond_met(ins[29:27], m_flags) ? ins[7:0] : m_pc + 8'd1;
            m_retired++;
        end else begin
            check("halt_w", W, 0);
            nxt = m_pc;
            m_halted = 1'b1;
        end
        exp_q.push_back(nxt);
        tick();
        start = 1'b0;
        m_pc = exp_q.pop_front();
        check("next_pc", pc, m_pc);
        check("post_w", W, 0);
        check("done", done, m_halted ? 1 : 0);
        check("busy", busy, m_halted ? 0 : 1);
`ifdef SEQ_RETIRE_COUNT_EN
        check("retired", retired, m_retired);
`endif
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        status = 4'd0;
        for (int i = 0; i < 256; i++) rom[i] = f_halt();
        rom[0]    = f_alu_imm(5'b00100, 5'd1, 5'd31, 15'd5);
        rom[1]    = f_alu_reg(5'b00010, 5'd2, 5'd1, 5'd1);
        rom[2]    = f_alu_imm(5'd3, 5'd3, 5'd2, 15'h7fff);
        rom[3]    = f_alu_reg(5'd7, 5'd4, 5'd3, 5'd2);
        rom[4]    = f_branch(COND_Z, 8'h10);
        rom[5]    = f_halt();
        rom[8'h10] = f_halt();
        tick();
        tick();
        reset = 1'b0;
        model_reset();

        // reset state
        check("rst_state", fsm_state, ST_IDLE);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_w", W, 0);
        check("rst_k", K, 0);
        check("rst_ctrl", {DA, SA, SB, FS, BS}, 0);
`ifdef SEQ_RETIRE_COUNT_EN
        check("rst_retired", retired, 0);
`endif

        // reset during an EXEC with W high
        do_start();
        tick();
        tick();
        check("pre_rst_w", W, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("midrst_w", W, 0);
        check("midrst_state", fsm_state, ST_IDLE);
        check("midrst_pc", pc, 0);
        check("midrst_busy", busy, 0);

        // directed program, taken branch (Z set by the ALU just before it)
        do_start();
        exec_one(-1);
        exec_one(-1);
        exec_one(-1);
        exec_one(1);
        exec_one(-1);
        exec_one(-1);
        tick();
        tick();
        check("halt_hold_pc", pc, 8'h10);
        check("halt_hold_done", done, 1);

        // restart from HALT, branch not taken
        do_start();
        exec_one(-1);
        exec_one(-1);
        exec_one(-1);
        exec_one(0);
        exec_one(-1);
        exec_one(-1);
        check("nt_halt_pc", pc, 5);

        // flags zero after reset, pc wrap at 0xFF
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        rom[0]    = f_branch(COND_Z, 8'h55);
        rom[1]    = f_branch(COND_ALWAYS, 8'hff);
        rom[8'hff] = f_alu_imm(5'd9, 5'd9, 5'd9, 15'd9);
        do_start();
        for (int i = 0; i < 4; i++) exec_one(-1);

        // branch to its own address
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        rom[0] = f_branch(COND_ALWAYS, 8'h00);
        do_start();
        for (int i = 0; i < 3; i++) exec_one(-1);
        check("self_loop_pc", pc, 0);

        // random program
        for (int i = 0; i < 256; i++) begin
            logic [31:0] r;
            int          k;
            r = $urandom;
            k = $urandom_range(0, 15);
            if (k <= 5)       rom[i] = {2'b00, r[29:0]};
            else if (k <= 10) rom[i] = {2'b01, r[29:0]};
            else if (k <= 14) rom[i] = {2'b10, r[29:0]};
            else              rom[i] = {2'b11, r[29:0]};
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        do_start();
        for (int n = 0; n < 300; n++) begin
            if (m_halted) do_start();
            else exec_one(-1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
